// File: rtl/rng_harvester.sv
// rng_harvester
// Turns the free-running x/y/z trajectory of the chaos generator into a stream
// of 32-bit random words. After enable it discards WARMUP sample strobes, then
// XOR-folds the low K bits of x, y and z on every strobe and packs them
// MSB-first into 32-bit words. Completed words go into a DEPTH-word FIFO that
// the consumer drains through a valid/ready handshake.
//
// Ports
//   clk        system clock (same clock as the chaos generator)
//   rst        asynchronous active-low reset
//   en         harvest enable; low returns to IDLE and discards the partial word
//   x, y, z    chaos state, sampled on the strobe cycle
//   rnd_data   FIFO head word, 0 when empty
//   rnd_valid  FIFO not empty
//   rnd_ready  consumer accepts the head word
//   level      FIFO occupancy 0..DEPTH
//   overflow   sticky: a completed word was dropped because the FIFO was full
//   ovf_clr    clears overflow (a drop in the same cycle wins)
//   state      0=IDLE, 1=WARMUP, 2=HARVEST
//
// FSM states
//   state      | meaning
//   ST_IDLE    | disabled; counters and partial word held at 0, FIFO drainable
//   ST_WARMUP  | counting WARMUP strobes to skip the start-up transient
//   ST_HARVEST | packing folded bits and pushing completed words
module rng_harvester #(
  parameter int K      = 8,
  parameter int DECIM  = 4,
  parameter int WARMUP = 1024,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [31:0]              x,
  input  logic [31:0]              y,
  input  logic [31:0]              z,
  output logic [31:0]              rnd_data,
  output logic                     rnd_valid,
  input  logic                     rnd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     ovf_clr,
  output logic [1:0]               state
);

  localparam int SLOTS = 32 / K;
  localparam int DW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int WW    = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = AW + 1;

  localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);
  localparam logic [WW-1:0] WARM_LAST  = WW'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOTS - 1);
  localparam logic [LW-1:0] DEPTH_L    = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_HARVEST = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [DW-1:0]   r_decim_cnt;
  logic [WW-1:0]   r_warm_cnt;
  logic [SW-1:0]   r_slot_cnt;
  logic [31:0]     r_pack;

  logic [31:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_overflow;

  logic            w_strobe;
  logic [K-1:0]    w_fb;
  logic [31:0]     w_word;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_wr;
  logic            w_drop;
  logic            w_valid;

  // ---------------------------------------------------------------------------
  // Sample strobe and folded bits
  // ---------------------------------------------------------------------------
  assign w_strobe = (r_state != ST_IDLE) && (r_decim_cnt == DECIM_LAST);
  assign w_fb     = x[K-1:0] ^ y[K-1:0] ^ z[K-1:0];

  // Next pack value: shift left by K and append the new sample, so the first
  // sample of a word ends up in the MSBs.
  generate
    if (K == 32) begin : g_pack_full
      assign w_word = w_fb;
    end else begin : g_pack_shift
      assign w_word = {r_pack[31-K:0], w_fb};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = (WARMUP == 0) ? ST_HARVEST : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        if (w_strobe && (r_warm_cnt == WARM_LAST)) begin
          w_state_nxt = ST_HARVEST;
        end
      end
      ST_HARVEST: begin
        w_state_nxt = ST_HARVEST;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Dropping enable wins over every other transition.
    if (!en) begin
      w_state_nxt = ST_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Decimation, warm-up and packing counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_decim_cnt <= '0;
    end else if (!en || (r_state == ST_IDLE)) begin
      r_decim_cnt <= '0;
    end else if (w_strobe) begin
      r_decim_cnt <= '0;
    end else begin
      r_decim_cnt <= r_decim_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_warm_cnt <= '0;
    end else if (!en || (r_state != ST_WARMUP)) begin
      r_warm_cnt <= '0;
    end else if (w_strobe) begin
      r_warm_cnt <= (r_warm_cnt == WARM_LAST) ? '0 : (r_warm_cnt + WW'(1));
    end
  end

  // The partial word is discarded whenever we are not harvesting, so a
  // re-enable never mixes stale bits into the first new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot_cnt <= '0;
      r_pack     <= '0;
    end else if (!en || (r_state != ST_HARVEST)) begin
      r_slot_cnt <= '0;
      r_pack     <= '0;
    end else if (w_strobe) begin
      r_pack     <= w_word;
      r_slot_cnt <= (r_slot_cnt == SLOT_LAST) ? '0 : (r_slot_cnt + SW'(1));
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  assign w_push  = en && (r_state == ST_HARVEST) && w_strobe &&
                   (r_slot_cnt == SLOT_LAST);
  assign w_valid = (r_level != '0);
  assign w_pop   = w_valid && rnd_ready;
  assign w_full  = (r_level == DEPTH_L);
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rnd_valid = w_valid;
  assign rnd_data  = w_valid ? r_mem[r_rd_ptr] : 32'h0;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign state     = r_state;

endmodule

// File: tb/tb_rng_harvester.sv
`timescale 1ns/1ps
module tb_rng_harvester;

  // Instance A: default-like configuration with a short warm-up.
  localparam int A_K      = 8;
  localparam int A_DECIM  = 4;
  localparam int A_WARMUP = 4;
  localparam int A_DEPTH  = 8;
  localparam int A_SLOTS  = 32 / A_K;
  localparam logic [31:0] A_MASK = 32'h0000_00FF;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        en, rnd_ready, ovf_clr, rnd_valid, overflow;
  logic [31:0] x, y, z, rnd_data;
  logic [3:0]  level;
  logic [1:0]  state;

  logic        en_b, rnd_ready_b, ovf_clr_b, rnd_valid_b, overflow_b;
  logic [31:0] x_b, y_b, z_b, rnd_data_b;
  logic [2:0]  level_b;
  logic [1:0]  state_b;

  rng_harvester #(.K(A_K), .DECIM(A_DECIM), .WARMUP(A_WARMUP), .DEPTH(A_DEPTH)) u_dut (
    .clk(clk), .rst(rst), .en(en), .x(x), .y(y), .z(z),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .state(state)
  );

  // Instance B: no warm-up, one sample per cycle.
  rng_harvester #(.K(8), .DECIM(1), .WARMUP(0), .DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(en_b), .x(x_b), .y(y_b), .z(z_b),
    .rnd_data(rnd_data_b), .rnd_valid(rnd_valid_b), .rnd_ready(rnd_ready_b),
    .level(level_b), .overflow(overflow_b), .ovf_clr(ovf_clr_b), .state(state_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model for instance A: time is counted in edges since enable,
  // strobe number k = edges/DECIM, strobes beyond WARMUP are samples.
  bit          m_active;
  int          m_c;
  logic [31:0] m_pack;
  logic [31:0] m_q[$];
  bit          m_ovf, m_pushed, m_dropped;

  function automatic logic [1:0] m_state();
    if (!m_active) return 2'd0;
    if ((m_c / A_DECIM) < A_WARMUP) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] m_head();
    return (m_q.size() > 0) ? m_q[0] : 32'h0;
  endfunction

  function automatic bit next_push();
    int c1, k;
    if (!(en && m_active)) return 1'b0;
    c1 = m_c + 1;
    if ((c1 % A_DECIM) != 0) return 1'b0;
    k = c1 / A_DECIM;
    return (k > A_WARMUP) && (((k - A_WARMUP - 1) % A_SLOTS) == A_SLOTS - 1);
  endfunction

  task automatic m_reset();
    m_active = 0; m_c = 0; m_pack = 0; m_q.delete();
    m_ovf = 0; m_pushed = 0; m_dropped = 0;
  endtask

  // Advance model and both DUTs by one clock edge; returns at posedge+1.
  task automatic tick();
    logic [31:0] fb;
    bit pop, push, drop;
    int k, s;
    fb   = (x ^ y ^ z) & A_MASK;
    pop  = (m_q.size() > 0) && rnd_ready;
    push = 0;
    if (!en) begin
      m_active = 0; m_pack = 0;
    end else if (!m_active) begin
      m_active = 1; m_c = 0;
    end else begin
      m_c++;
      if ((m_c % A_DECIM) == 0) begin
        k = m_c / A_DECIM;
        if (k > A_WARMUP) begin
          m_pack = (m_pack << A_K) | fb;
          s = k - A_WARMUP - 1;
          if ((s % A_SLOTS) == A_SLOTS - 1) push = 1;
        end
      end
    end
    drop = push && (m_q.size() == A_DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (push && !drop) m_q.push_back(m_pack);
    if (drop) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    m_pushed = push && !drop;
    m_dropped = drop;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 0; rnd_ready = 0; ovf_clr = 0; x = 0; y = 0; z = 0;
    en_b = 0; rnd_ready_b = 0; ovf_clr_b = 0; x_b = 0; y_b = 0; z_b = 0;
    m_reset();
    #2;
    checks++;
    if (state !== 2'd0 || level !== 4'd0 || rnd_valid !== 1'b0 || rnd_data !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_a state=%0d level=%0d valid=%0b data=%h ovf=%0b want all 0", state, level, rnd_valid, rnd_data, overflow);
    end
    checks++;
    if (state_b !== 2'd0 || level_b !== 3'd0 || rnd_valid_b !== 1'b0 || rnd_data_b !== 32'h0 || overflow_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_b state=%0d level=%0d valid=%0b data=%h ovf=%0b want all 0", state_b, level_b, rnd_valid_b, rnd_data_b, overflow_b);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_first_word();
    int first;
    x = 32'hA5; y = 32'h3C; z = 32'h0; rnd_ready = 0; en = 1;
    first = -1;
    for (int i = 1; i <= 50 && first < 0; i++) begin
      tick();
      checks++;
      if (state !== m_state() || level !== 4'(m_q.size()) || rnd_valid !== (m_q.size() != 0) || rnd_data !== m_head() || overflow !== m_ovf) begin
        errors++;
        $display("FAIL first_word_cycle t=%0d state=%0d/%0d level=%0d/%0d data=%h/%h", i, state, m_state(), level, m_q.size(), rnd_data, m_head());
      end
      if (rnd_valid === 1'b1) first = i;
    end
    // tick 1 is the enabling edge E0, so the push edge E0+32 is tick 33
    checks++;
    if (first !== 33) begin
      errors++;
      $display("FAIL first_word_latency got=%0d want=32", first - 1);
    end
    checks++;
    if (rnd_data !== 32'h9999_9999 || level !== 4'd1 || state !== 2'd2) begin
      errors++;
      $display("FAIL first_word_value data=%h want=99999999 level=%0d want=1 state=%0d want=2", rnd_data, level, state);
    end
  endtask

  task automatic test_overflow();
    int n;
    rnd_ready = 0;
    n = 0;
    while (m_q.size() < A_DEPTH && n < 400) begin
      x = $urandom; y = $urandom; z = $urandom;
      tick(); n++;
      checks++;
      if (level !== 4'(m_q.size()) || rnd_data !== m_head() || overflow !== m_ovf) begin
        errors++;
        $display("FAIL fill level=%0d/%0d data=%h/%h ovf=%0b/%0b", level, m_q.size(), rnd_data, m_head(), overflow, m_ovf);
      end
    end
    checks++;
    if (level !== 4'd8) begin
      errors++;
      $display("FAIL full_level got=%0d want=8", level);
    end
    n = 0;
    do begin
      x = $urandom; y = $urandom; z = $urandom;
      tick(); n++;
    end while (!m_dropped && n < 40);
    checks++;
    if (!m_dropped || overflow !== 1'b1 || level !== 4'd8 || rnd_data !== 32'h9999_9999) begin
      errors++;
      $display("FAIL drop_9th ovf=%0b want=1 level=%0d want=8 head=%h want=99999999", overflow, level, rnd_data);
    end
    ovf_clr = 1; tick(); ovf_clr = 0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr got=%0b want=0", overflow);
    end
    n = 0;
    while (!next_push() && n < 40) begin
      x = $urandom; y = $urandom; z = $urandom;
      tick(); n++;
    end
    rnd_ready = 1; tick(); rnd_ready = 0;
    checks++;
    if (!m_pushed || level !== 4'd8 || overflow !== 1'b0 || rnd_data !== m_head()) begin
      errors++;
      $display("FAIL pop_on_push_full level=%0d want=8 ovf=%0b want=0 head=%h want=%h", level, overflow, rnd_data, m_head());
    end
    n = 0;
    do begin
      x = $urandom; y = $urandom; z = $urandom;
      tick(); n++;
    end while (!m_dropped && n < 40);
    checks++;
    if (!m_dropped || overflow !== 1'b1 || level !== 4'd8) begin
      errors++;
      $display("FAIL drop_again ovf=%0b want=1 level=%0d want=8", overflow, level);
    end
  endtask

  task automatic test_reset_mid();
    en = 0; rnd_ready = 1;
    repeat (5) tick();
    rnd_ready = 0;
    checks++;
    if (level !== 4'd3 || overflow !== 1'b1 || rnd_data !== m_head()) begin
      errors++;
      $display("FAIL drain_to_3 level=%0d want=3 ovf=%0b want=1 data=%h want=%h", level, overflow, rnd_data, m_head());
    end
    en = 1;
    repeat (20) begin
      x = $urandom; y = $urandom; z = $urandom;
      tick();
    end
    checks++;
    if (state !== 2'd2 || level !== 4'd3) begin
      errors++;
      $display("FAIL pre_reset state=%0d want=2 level=%0d want=3", state, level);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || level !== 4'd0 || rnd_valid !== 1'b0 || rnd_data !== 32'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL async_reset state=%0d level=%0d valid=%0b data=%h ovf=%0b want all 0", state, level, rnd_valid, rnd_data, overflow);
    end
    m_reset();
    en = 0;
    #1 rst = 1'b1;
  endtask

  task automatic test_handshake();
    int n;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    logic        pv, pr;
    logic [31:0] pd;
    en = 1; rnd_ready = 0;
    n = 0;
    while (m_q.size() < 4 && n < 200) begin
      x = $urandom; y = $urandom; z = $urandom;
      tick(); n++;
    end
    en = 0;
    exp_q = m_q;
    for (int i = 0; i < 20; i++) begin
      rnd_ready = i[0];
      if (rnd_valid && rnd_ready) got_q.push_back(rnd_data);
      pv = rnd_valid; pr = rnd_ready; pd = rnd_data;
      tick();
      if (pv && !pr) begin
        checks++;
        if (rnd_valid !== 1'b1 || rnd_data !== pd) begin
          errors++;
          $display("FAIL hold_stable valid=%0b want=1 data=%h want=%h", rnd_valid, rnd_data, pd);
        end
      end
      checks++;
      if (level !== 4'(m_q.size()) || rnd_data !== m_head() || state !== 2'd0) begin
        errors++;
        $display("FAIL drain level=%0d/%0d data=%h/%h state=%0d want=0", level, m_q.size(), rnd_data, m_head(), state);
      end
    end
    rnd_ready = 0;
    checks++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL pop_count got=%0d want=4", got_q.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (got_q[j] !== exp_q[j]) begin
          errors++;
          $display("FAIL pop_order idx=%0d got=%h want=%h", j, got_q[j], exp_q[j]);
        end
      end
    end
    checks++;
    if (rnd_valid !== 1'b0 || level !== 4'd0 || rnd_data !== 32'h0) begin
      errors++;
      $display("FAIL empty_after_drain valid=%0b level=%0d data=%h want 0", rnd_valid, level, rnd_data);
    end
  endtask

  task automatic test_enable_drop();
    int n, first, warm_cycles;
    en = 1; rnd_ready = 1;
    n = 0;
    while (!(m_active && m_c == A_DECIM * (A_WARMUP + 2)) && n < 100) begin
      x = $urandom; y = $urandom; z = $urandom;
      tick(); n++;
    end
    checks++;
    if (state !== 2'd2 || level !== 4'd0) begin
      errors++;
      $display("FAIL mid_harvest state=%0d want=2 level=%0d want=0", state, level);
    end
    en = 0;
    tick();
    checks++;
    if (state !== 2'd0 || level !== 4'd0 || rnd_valid !== 1'b0) begin
      errors++;
      $display("FAIL en_drop state=%0d want=0 level=%0d want=0 valid=%0b want=0", state, level, rnd_valid);
    end
    repeat (3) tick();
    en = 1;
    first = -1; warm_cycles = 0;
    for (int i = 1; i <= 50 && first < 0; i++) begin
      x = $urandom; y = $urandom; z = $urandom;
      tick();
      if (state === 2'd1) warm_cycles++;
      checks++;
      if (state !== m_state() || level !== 4'(m_q.size()) || rnd_data !== m_head()) begin
        errors++;
        $display("FAIL reenable t=%0d state=%0d/%0d level=%0d/%0d data=%h/%h", i, state, m_state(), level, m_q.size(), rnd_data, m_head());
      end
      if (rnd_valid === 1'b1) first = i;
    end
    checks++;
    if (warm_cycles != A_DECIM * A_WARMUP || first != 33) begin
      errors++;
      $display("FAIL rewarm warm_cycles=%0d want=%0d latency=%0d want=32", warm_cycles, A_DECIM * A_WARMUP, first - 1);
    end
  endtask

  task automatic test_packing_order();
    logic [7:0] vals[4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    x_b = 0; y_b = 0; z_b = 0; rnd_ready_b = 0; en_b = 1;
    tick();
    checks++;
    if (state_b !== 2'd2) begin
      errors++;
      $display("FAIL no_warmup_state got=%0d want=2", state_b);
    end
    for (int j = 0; j < 4; j++) begin
      x_b = {24'h0, vals[j]};
      tick();
      if (j < 3) begin
        checks++;
        if (rnd_valid_b !== 1'b0) begin
          errors++;
          $display("FAIL pack_early j=%0d valid=%0b want=0", j, rnd_valid_b);
        end
      end
    end
    checks++;
    if (rnd_valid_b !== 1'b1 || rnd_data_b !== 32'h1122_3344 || level_b !== 3'd1) begin
      errors++;
      $display("FAIL pack_order valid=%0b data=%h want=11223344 level=%0d want=1", rnd_valid_b, rnd_data_b, level_b);
    end
    rnd_ready_b = 1; en_b = 0;
    tick();
    rnd_ready_b = 0;
    checks++;
    if (rnd_valid_b !== 1'b0 || level_b !== 3'd0 || state_b !== 2'd0) begin
      errors++;
      $display("FAIL pack_pop valid=%0b level=%0d state=%0d want all 0", rnd_valid_b, level_b, state_b);
    end
  endtask

  task automatic test_random();
    int pr_tab[6];
    int pr;
    pr_tab[0] = 0; pr_tab[1] = 50; pr_tab[2] = 10; pr_tab[3] = 90; pr_tab[4] = 30; pr_tab[5] = 5;
    for (int i = 0; i < 3000; i++) begin
      pr = pr_tab[(i / 300) % 6];
      x = $urandom; y = $urandom; z = $urandom;
      en = ($urandom_range(0, 199) != 0);
      rnd_ready = ($urandom_range(0, 99) < pr);
      ovf_clr = ($urandom_range(0, 99) < 3);
      tick();
      checks++;
      if (state !== m_state() || level !== 4'(m_q.size()) || rnd_valid !== (m_q.size() != 0) || rnd_data !== m_head() || overflow !== m_ovf) begin
        errors++;
        $display("FAIL random i=%0d state=%0d/%0d level=%0d/%0d valid=%0b data=%h/%h ovf=%0b/%0b", i, state, m_state(), level, m_q.size(), rnd_valid, rnd_data, m_head(), overflow, m_ovf);
      end
    end
    ovf_clr = 0; rnd_ready = 0;
  endtask

  initial begin
    test_reset();
    test_first_word();
    test_overflow();
    test_reset_mid();
    test_handshake();
    test_enable_drop();
    test_packing_order();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
